// File: rtl/sram_client_arbiter.sv
// rtl/sram_client_arbiter.sv - SRAM port arbiter for UART/VGA/milestone clients
// Fixed-priority or round-robin grant with burst limit, lock, one-cycle handover gap and read tags.
module sram_client_arbiter #(
  parameter int NUM_CLIENTS    = 4,
  parameter int ADDR_W         = 18,
  parameter int DATA_W         = 16,
  parameter int READ_LATENCY   = 2,
  parameter int ROUND_ROBIN    = 0,
  parameter int MAX_BURST      = 256,
  parameter int DEFAULT_CLIENT = 0
) (
  input  logic                            CLOCK_50_I,
  input  logic                            resetn,
  input  logic [NUM_CLIENTS-1:0]          req_i,
  input  logic [NUM_CLIENTS-1:0]          lock_i,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]   addr_i,
  input  logic [NUM_CLIENTS*DATA_W-1:0]   wdata_i,
  input  logic [NUM_CLIENTS-1:0]          we_n_i,
  output logic [NUM_CLIENTS-1:0]          gnt_o,
  output logic [NUM_CLIENTS-1:0]          rvalid_o,
  output logic [DATA_W-1:0]               rdata_o,
  output logic [$clog2(NUM_CLIENTS)-1:0]  active_client_o,
  output logic                            busy_o,
  output logic [ADDR_W-1:0]               SRAM_address_o,
  output logic [DATA_W-1:0]               SRAM_write_data_o,
  output logic                            SRAM_we_n_o,
  input  logic [DATA_W-1:0]               SRAM_read_data_i
);

  localparam int IDW = $clog2(NUM_CLIENTS);
  localparam int CW  = $clog2(MAX_BURST);

  typedef enum logic [1:0] {S_ARB_IDLE, S_ARB_GRANT, S_ARB_SWITCH} arb_state_t;

  arb_state_t     state;
  logic [IDW-1:0] active_q;
  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  burst_cnt;
  logic           tag_v  [READ_LATENCY];
  logic [IDW-1:0] tag_id [READ_LATENCY];

  logic           granted;
  logic           any_req;
  logic           others_req;
  logic           release_now;
  logic           push;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] ptr_next;

  // rr_ptr is the first index searched, i.e. (last granted + 1) mod NUM_CLIENTS.
  function automatic logic [IDW-1:0] pick(input logic [NUM_CLIENTS-1:0] r, input logic [IDW-1:0] p);
    logic [IDW-1:0] w;
    logic [IDW-1:0] idx;
    logic           found;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      idx = (ROUND_ROBIN != 0) ? IDW'((int'(p) + i) % NUM_CLIENTS) : IDW'(i);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign granted     = (state == S_ARB_GRANT);
  assign any_req     = |req_i;
  assign others_req  = |(req_i & ~(NUM_CLIENTS'(1) << active_q));
  assign release_now = !req_i[active_q] ||
                       ((burst_cnt == CW'(MAX_BURST - 1)) && !lock_i[active_q] && others_req);
  assign push        = granted && req_i[active_q] && we_n_i[active_q];
  assign winner      = pick(req_i, rr_ptr);
  assign ptr_next    = (winner == IDW'(NUM_CLIENTS - 1)) ? '0 : winner + IDW'(1);

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state     <= S_ARB_IDLE;
      gnt_o     <= '0;
      active_q  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        S_ARB_IDLE, S_ARB_SWITCH: begin
          if (any_req) begin
            state     <= S_ARB_GRANT;
            gnt_o     <= NUM_CLIENTS'(1) << winner;
            active_q  <= winner;
            rr_ptr    <= ptr_next;
            burst_cnt <= '0;
          end else begin
            state <= S_ARB_IDLE;
          end
        end
        S_ARB_GRANT: begin
          if (release_now) begin
            state <= S_ARB_SWITCH;
            gnt_o <= '0;
          end else if (burst_cnt != CW'(MAX_BURST - 1)) begin
            burst_cnt <= burst_cnt + CW'(1);
          end
        end
        default: begin
          state <= S_ARB_IDLE;
          gnt_o <= '0;
        end
      endcase
    end
  end

  // Tags keep shifting regardless of state so reads issued before a release still return.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_v[i]  <= 1'b0;
        tag_id[i] <= '0;
      end
    end else begin
      tag_v[0]  <= push;
      tag_id[0] <= active_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      rvalid_o[k] = tag_v[READ_LATENCY-1] && (tag_id[READ_LATENCY-1] == IDW'(k));
    end
  end

  always_comb begin
    SRAM_address_o    = addr_i[DEFAULT_CLIENT*ADDR_W +: ADDR_W];
    SRAM_write_data_o = '0;
    SRAM_we_n_o       = 1'b1;
    if (granted) begin
      SRAM_address_o    = addr_i[int'(active_q)*ADDR_W +: ADDR_W];
      SRAM_write_data_o = wdata_i[int'(active_q)*DATA_W +: DATA_W];
      SRAM_we_n_o       = we_n_i[active_q];
    end
  end

  assign rdata_o         = SRAM_read_data_i;
  assign active_client_o = active_q;
  assign busy_o          = |gnt_o;

endmodule

// File: tb/tb_sram_client_arbiter.sv
// tb/tb_sram_client_arbiter.sv - directed bench for sram_client_arbiter
// Fixed-priority instance plus a round-robin instance sharing the same client stimulus.
module tb_sram_client_arbiter;

  localparam int N  = 4;
  localparam int AW = 18;
  localparam int DW = 16;

  logic            clk;
  logic            resetn;
  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    we_n;
  logic [DW-1:0]   sram_rd;
  logic [AW-1:0]   a1, a2;

  logic [N-1:0]    gnt, rvalid, gnt_rr, rvalid_rr;
  logic [DW-1:0]   rdata, rdata_rr, sram_wd, sram_wd_rr;
  logic [1:0]      active, active_rr;
  logic            busy, busy_rr, sram_we_n, sram_we_n_rr;
  logic [AW-1:0]   sram_addr, sram_addr_rr;

  int n_tests = 0;
  int n_fail  = 0;

  sram_client_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2),
                        .ROUND_ROBIN(0), .MAX_BURST(4), .DEFAULT_CLIENT(0)) dut (
    .CLOCK_50_I(clk), .resetn(resetn), .req_i(req), .lock_i(lock), .addr_i(addr),
    .wdata_i(wdata), .we_n_i(we_n), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .active_client_o(active), .busy_o(busy), .SRAM_address_o(sram_addr),
    .SRAM_write_data_o(sram_wd), .SRAM_we_n_o(sram_we_n), .SRAM_read_data_i(sram_rd));

  sram_client_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2),
                        .ROUND_ROBIN(1), .MAX_BURST(4), .DEFAULT_CLIENT(0)) dut_rr (
    .CLOCK_50_I(clk), .resetn(resetn), .req_i(req), .lock_i(lock), .addr_i(addr),
    .wdata_i(wdata), .we_n_i(we_n), .gnt_o(gnt_rr), .rvalid_o(rvalid_rr), .rdata_o(rdata_rr),
    .active_client_o(active_rr), .busy_o(busy_rr), .SRAM_address_o(sram_addr_rr),
    .SRAM_write_data_o(sram_wd_rr), .SRAM_we_n_o(sram_we_n_rr), .SRAM_read_data_i(sram_rd));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Two-cycle SRAM read model: data for address a is a[15:0] ^ 16'hA5A5.
  always @(posedge clk) begin
    a1 <= sram_addr;
    a2 <= a1;
  end
  assign sram_rd = a2[15:0] ^ 16'hA5A5;

  function automatic logic [15:0] sram_val(input int v);
    return 16'(v) ^ 16'hA5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int k, input int v);
    addr[k*AW +: AW] = AW'(v);
  endtask

  initial begin
    resetn = 1'b0; req = '0; lock = '0; addr = '0; wdata = '0; we_n = '1;
    tick; tick;
    check("rst_gnt",    32'(gnt), 0);
    check("rst_busy",   32'(busy), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_active", 32'(active), 0);
    check("rst_we_n",   32'(sram_we_n), 1);
    resetn = 1'b1;

    // Client 0 reads addresses 0,1,2 then releases.
    tick; req = 4'b0001; set_addr(0, 0); #1;
    check("t1_idle_gnt", 32'(gnt), 0);
    for (int i = 0; i < 6; i++) begin
      tick;
      req = (i < 3) ? 4'b0001 : 4'b0000;
      set_addr(0, i);
      #1;
      check("t1_gnt",    32'(gnt), (i < 4) ? 1 : 0);
      check("t1_rvalid", 32'(rvalid), (i >= 2 && i <= 4) ? 1 : 0);
      if (i >= 2 && i <= 4) check("t1_rdata", 32'(rdata), 32'(sram_val(i - 2)));
      check("t1_addr",   32'(sram_addr), i);
    end

    // Fixed priority: 1 beats 3, then a single gap, then 3.
    tick; req = 4'b1010; #1;
    check("t2_idle_gnt", 32'(gnt), 0);
    tick; #1;
    check("t2_gnt1", 32'(gnt), 4'b0010);
    check("t2_act1", 32'(active), 1);
    check("t2_busy", 32'(busy), 1);
    tick; req = 4'b1000; #1;
    check("t2_gnt1_rel", 32'(gnt), 4'b0010);
    tick; #1;
    check("t2_switch_gnt",  32'(gnt), 0);
    check("t2_switch_busy", 32'(busy), 0);
    tick; req = 4'b0000; #1;
    check("t2_gnt3", 32'(gnt), 4'b1000);
    check("t2_act3", 32'(active), 3);
    tick; tick;

    // Round-robin rotation with MAX_BURST=4 from a fresh reset.
    resetn = 1'b0; tick; resetn = 1'b1;
    req = 4'b1111; #1;
    check("t3_idle_gnt", 32'(gnt_rr), 0);
    for (int j = 0; j < 24; j++) begin
      tick;
      check("t3_rr_gnt", 32'(gnt_rr), ((j % 5) < 4) ? (1 << ((j / 5) % 4)) : 0);
    end
    req = 4'b0000;
    tick; tick; tick;

    // Locked client 2 is not force-released while client 0 waits.
    req = 4'b0100; lock = 4'b0100;
    tick; req = 4'b0101; #1;
    check("t4_gnt2", 32'(gnt), 4'b0100);
    for (int j = 0; j < 8; j++) begin
      tick;
      check("t4_locked", 32'(gnt), 4'b0100);
    end
    tick; req = 4'b0001; #1;
    check("t4_rel_cycle", 32'(gnt), 4'b0100);
    tick; #1;
    check("t4_switch", 32'(gnt), 0);
    tick; req = 4'b0000; lock = 4'b0000; #1;
    check("t4_gnt0", 32'(gnt), 4'b0001);
    tick; tick;

    // Client 1 writes, reads on its last cycle, releases; client 2 takes over.
    req = 4'b0010; we_n = 4'b1101; set_addr(1, 9); wdata[1*DW +: DW] = 16'h1234;
    tick; #1;
    check("t5_gnt1",    32'(gnt), 4'b0010);
    check("t5_we_n",    32'(sram_we_n), 0);
    check("t5_wdata",   32'(sram_wd), 32'h1234);
    check("t5_waddr",   32'(sram_addr), 9);
    tick; we_n = 4'b1111; set_addr(1, 5); req = 4'b0110; #1;
    check("t5_raddr",   32'(sram_addr), 5);
    tick; req = 4'b0100; #1;
    check("t5_rel_gnt", 32'(gnt), 4'b0010);
    check("t5_rel_rv",  32'(rvalid), 0);
    tick; #1;
    check("t5_sw_rv",    32'(rvalid), 4'b0010);
    check("t5_sw_rdata", 32'(rdata), 32'(sram_val(5)));
    check("t5_sw_gnt",   32'(gnt), 0);
    check("t5_sw_we_n",  32'(sram_we_n), 1);
    check("t5_sw_wdata", 32'(sram_wd), 0);
    tick; req = 4'b0000; #1;
    check("t5_gnt2",  32'(gnt), 4'b0100);
    check("t5_g2_rv", 32'(rvalid), 0);
    tick; #1;
    check("t5_sw2_rv", 32'(rvalid), 0);
    tick; #1;
    check("t5_idle_rv", 32'(rvalid), 0);

    // Asynchronous reset in the middle of a write burst.
    req = 4'b0001; we_n = 4'b1110; set_addr(0, 7); wdata[0 +: DW] = 16'hBEEF;
    tick; #1;
    check("t6_we_n_low", 32'(sram_we_n), 0);
    check("t6_gnt",      32'(gnt), 4'b0001);
    tick; resetn = 1'b0; #1;
    check("t6_rst_gnt",  32'(gnt), 0);
    check("t6_rst_we_n", 32'(sram_we_n), 1);
    check("t6_rst_busy", 32'(busy), 0);
    tick; req = 4'b0000; we_n = 4'b1111;
    tick; resetn = 1'b1; #1;
    tick; #1;
    check("t6_idle_gnt",  32'(gnt), 0);
    check("t6_idle_busy", 32'(busy), 0);
    check("t6_idle_addr", 32'(sram_addr), 7);
    check("t6_idle_we_n", 32'(sram_we_n), 1);
    check("t6_idle_rv",   32'(rvalid), 0);
    check("t6_idle_act",  32'(active), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_client_arbiter.md
# sram_client_arbiter

Parametrised SRAM access arbiter for the decompressor top level, replacing the hard-wired state-based multiplexing of UART, VGA and milestone units onto the single SRAM controller port. It grants the SRAM port to one of NUM_CLIENTS requesters under fixed-priority or round-robin policy, with burst limits, lock support and a one-cycle handover gap. Read data is returned with a per-client valid strobe aligned to the SRAM controller's read latency. It sits between the client units and SRAM_Controller.

## Interface
- NUM_CLIENTS, 4: number of requesters (2..8).
- ADDR_W, 18: SRAM address width.
- DATA_W, 16: SRAM data width.
- READ_LATENCY, 2: cycles from address issue to valid SRAM_read_data_i (1..4).
- ROUND_ROBIN, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
- MAX_BURST, 256: grant cycles before a forced release is considered (power of two, ≥2).
- DEFAULT_CLIENT, 0: client whose address drives SRAM when no grant is held.

Ports:
- CLOCK_50_I  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- req_i  in  NUM_CLIENTS  per-client access request, level.
- lock_i  in  NUM_CLIENTS  suppresses forced release for that client.
- addr_i  in  NUM_CLIENTS*ADDR_W  packed client addresses, client k at [k*ADDR_W +: ADDR_W].
- wdata_i  in  NUM_CLIENTS*DATA_W  packed client write data.
- we_n_i  in  NUM_CLIENTS  per-client write enable, active-low.
- gnt_o  out  NUM_CLIENTS  one-hot grant, registered.
- rvalid_o  out  NUM_CLIENTS  read-data-valid strobe per client.
- rdata_o  out  DATA_W  SRAM_read_data_i passed through.
- active_client_o  out  $clog2(NUM_CLIENTS)  index of granted client (last granted when idle).
- busy_o  out  1  high while any grant is held.
- SRAM_address_o  out  ADDR_W  to SRAM_Controller.
- SRAM_write_data_o  out  DATA_W  to SRAM_Controller.
- SRAM_we_n_o  out  1  to SRAM_Controller.
- SRAM_read_data_i  in  DATA_W  from SRAM_Controller.

## Operation
- States: S_ARB_IDLE, S_ARB_GRANT, S_ARB_SWITCH.
- S_ARB_IDLE: if any req_i, select winner k per policy; next cycle S_ARB_GRANT with gnt_o = 1<<k, burst counter = 0. Otherwise stay.
- S_ARB_GRANT: SRAM_address_o/write_data_o/we_n_o combinationally follow client k. Burst counter increments per cycle, saturating at MAX_BURST-1.
- Release from S_ARB_GRANT to S_ARB_SWITCH when req_i[k]=0, or when counter = MAX_BURST-1 and lock_i[k]=0 and another req_i bit is set.
- S_ARB_SWITCH: gnt_o = 0, SRAM_we_n_o = 1; arbitration is evaluated here. Next state is S_ARB_GRANT to the new winner, or S_ARB_IDLE if no requests.
- With no grant held (IDLE, SWITCH): SRAM_address_o = addr_i[DEFAULT_CLIENT], SRAM_we_n_o = 1, SRAM_write_data_o = 0.
- Fixed priority: lowest set index wins. Round-robin: search starts at (last granted + 1) mod NUM_CLIENTS; pointer updates on each grant.
- Read tag pipeline: READ_LATENCY stages of {valid, client id}. Pushes valid=1, id=k each S_ARB_GRANT cycle with we_n_i[k]=1; otherwise pushes valid=0. At the output, rvalid_o[id] = valid. Tags already in flight drain normally across release and SWITCH.
- Writes return no strobe.
- A client that deasserts req_i then reasserts must be re-arbitrated; it loses at least the SWITCH cycle.

## Timing
- Reset values: state S_ARB_IDLE, gnt_o = 0, rvalid_o = 0, busy_o = 0, active_client_o = 0, RR pointer = 0, burst counter = 0, tag pipeline cleared, SRAM_we_n_o = 1.
- Reset is asynchronous. Asserting resetn mid-grant drops gnt_o and forces SRAM_we_n_o = 1 immediately. In-flight read tags are discarded.
- Grant latency: 1 cycle from req_i seen in IDLE. Handover gap: exactly 1 cycle with gnt_o = 0.
- Read return: rvalid_o asserted exactly READ_LATENCY cycles after the issuing GRANT cycle, for one cycle per issued read. Back-to-back reads yield a continuous strobe.
- A request arriving on the same cycle another is released is considered in SWITCH.
- gnt_o is never multi-hot. SRAM_we_n_o is never low outside S_ARB_GRANT.

## Test plan
- Reset, then req_i=0001 with reads to 0,1,2 (we_n=1) -> gnt_o=0001 one cycle later; rvalid_o[0] high for 3 cycles starting READ_LATENCY after the first address; rdata_o matches SRAM model.
- Fixed priority, req_i=1010 together -> client 1 granted; on its release, 1 SWITCH cycle, then client 3 granted.
- ROUND_ROBIN=1, req_i=1111 held, MAX_BURST=4 -> grants rotate 0,1,2,3,0, each 4 cycles with a 1-cycle gap.
- Client 2 holds lock_i[2]=1 past MAX_BURST with client 0 requesting -> no forced release until req_i[2] drops.
- Client 1 issues a read on its last grant cycle, then releases -> rvalid_o[1] still fires READ_LATENCY later during SWITCH or the next grant, with no strobe on the new client.
- resetn low mid-write burst -> SRAM_we_n_o=1 and gnt_o=0 in the same cycle; after release the block is idle with SRAM_address_o = addr_i[DEFAULT_CLIENT].
